// File: rtl/rsa_ctrl_pkg.sv
// Shared types and widths for the RSA byte-stream controller.
package rsa_ctrl_pkg;

  localparam int WORD_W = 256;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_GET_N = 3'd0,
    S_GET_D = 3'd1,
    S_GET_A = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_SEND  = 3'd5
  } state_t;

  function automatic state_t next_rx_state(input state_t s);
    case (s)
      S_GET_N: return S_GET_D;
      S_GET_D: return S_GET_A;
      default: return S_START;
    endcase
  endfunction

endpackage

// File: rtl/rsa_byte_shifter.sv
// Byte-wide shift register: parallel load, shift a byte in at the LSB end,
// or shift out towards the MSB end with zero fill.
module rsa_byte_shifter
  import rsa_ctrl_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [W-1:0]      load_data_i,
  input  logic              shift_in_i,
  input  logic              shift_out_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [W-1:0]      data_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // Next value: load has priority over either shift direction.
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = load_data_i;
    end else if (shift_in_i) begin
      data_d = {data_q[W-BYTE_W-1:0], byte_i};
    end else if (shift_out_i) begin
      data_d = {data_q[W-BYTE_W-1:0], {BYTE_W{1'b0}}};
    end else begin
      data_d = data_q;
    end
  end

  // Storage with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= {W{1'b0}};
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/rsa_stream_ctrl.sv
// Sequences one RSA core: assembles N/D/A from an rx byte stream, starts the
// core per block and streams the low result bytes back out MSB-first.
module rsa_stream_ctrl
  import rsa_ctrl_pkg::*;
#(
  parameter int BYTES_IN  = 32,
  parameter int BYTES_OUT = 31
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [BYTE_W-1:0] i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  input  logic              i_rekey,
  output logic [BYTE_W-1:0] o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_core_start,
  output logic [WORD_W-1:0] o_core_n,
  output logic [WORD_W-1:0] o_core_d,
  output logic [WORD_W-1:0] o_core_a,
  input  logic [WORD_W-1:0] i_core_a_pow_d,
  input  logic              i_core_finished,
  output logic              o_busy
);

  localparam int         TX_W     = BYTE_W * BYTES_OUT;
  localparam logic [5:0] IN_LAST  = 6'(BYTES_IN - 1);
  localparam logic [5:0] OUT_LAST = 6'(BYTES_OUT - 1);

  state_t          state_q;
  logic [5:0]      cnt_q;
  logic [TX_W-1:0] tx_q;
  logic            in_get_s;
  logic            rekey_s;
  logic            rx_fire_s;
  logic            tx_fire_s;
  logic            tx_load_s;
  logic            unused_s;

  assign in_get_s   = (state_q == S_GET_N) || (state_q == S_GET_D) || (state_q == S_GET_A);
  // A rekey is only honoured between blocks, and that cycle takes no byte.
  assign rekey_s    = (state_q == S_GET_A) && (cnt_q == 6'd0) && i_rekey;
  assign o_rx_ready = in_get_s && !rekey_s && !i_rst;
  assign rx_fire_s  = i_rx_valid && o_rx_ready;

  assign o_tx_valid   = (state_q == S_SEND);
  assign tx_fire_s    = o_tx_valid && i_tx_ready;
  assign tx_load_s    = (state_q == S_WAIT) && i_core_finished;
  assign o_core_start = (state_q == S_START);
  assign o_busy       = (state_q == S_START) || (state_q == S_WAIT) || (state_q == S_SEND);
  assign o_tx_data    = tx_q[TX_W-1 -: BYTE_W];
  assign unused_s     = ^i_core_a_pow_d[WORD_W-1:TX_W];

  // Block sequencing and the shared rx/tx byte counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_GET_N;
      cnt_q   <= 6'd0;
    end else begin
      case (state_q)
        S_GET_N, S_GET_D, S_GET_A: begin
          if (rekey_s) begin
            state_q <= S_GET_N;
            cnt_q   <= 6'd0;
          end else if (rx_fire_s) begin
            if (cnt_q == IN_LAST) begin
              cnt_q   <= 6'd0;
              state_q <= next_rx_state(state_q);
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end
        S_START: state_q <= S_WAIT;
        S_WAIT: begin
          if (i_core_finished) begin
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_fire_s) begin
            if (cnt_q == OUT_LAST) begin
              cnt_q   <= 6'd0;
              state_q <= S_GET_A;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end
        default: begin
          state_q <= S_GET_N;
          cnt_q   <= 6'd0;
        end
      endcase
    end
  end

  rsa_byte_shifter #(.W(WORD_W)) u_rx_n (
    .clk_i(i_clk), .rst_i(i_rst), .load_i(1'b0), .load_data_i({WORD_W{1'b0}}),
    .shift_in_i(rx_fire_s && (state_q == S_GET_N)), .shift_out_i(1'b0),
    .byte_i(i_rx_data), .data_o(o_core_n)
  );

  rsa_byte_shifter #(.W(WORD_W)) u_rx_d (
    .clk_i(i_clk), .rst_i(i_rst), .load_i(1'b0), .load_data_i({WORD_W{1'b0}}),
    .shift_in_i(rx_fire_s && (state_q == S_GET_D)), .shift_out_i(1'b0),
    .byte_i(i_rx_data), .data_o(o_core_d)
  );

  rsa_byte_shifter #(.W(WORD_W)) u_rx_a (
    .clk_i(i_clk), .rst_i(i_rst), .load_i(1'b0), .load_data_i({WORD_W{1'b0}}),
    .shift_in_i(rx_fire_s && (state_q == S_GET_A)), .shift_out_i(1'b0),
    .byte_i(i_rx_data), .data_o(o_core_a)
  );

  rsa_byte_shifter #(.W(TX_W)) u_tx (
    .clk_i(i_clk), .rst_i(i_rst), .load_i(tx_load_s), .load_data_i(i_core_a_pow_d[TX_W-1:0]),
    .shift_in_i(1'b0), .shift_out_i(tx_fire_s),
    .byte_i({BYTE_W{1'b0}}), .data_o(tx_q)
  );

endmodule

// File: tb/tb_rsa_stream_ctrl.sv
// Directed bench for rsa_stream_ctrl with a behavioural mock core and a
// byte scoreboard on the tx stream.
module tb_rsa_stream_ctrl;

  logic         clk = 1'b0;
  logic         rst, rx_valid, rekey, tx_ready, core_fin;
  logic [7:0]   rx_data, tx_data;
  logic         rx_ready, tx_valid, core_start, busy;
  logic [255:0] core_n, core_d, core_a, core_res;

  int  n_checks = 0;
  int  n_fail = 0;
  int  tx_seen = 0;
  int  start_cnt = 0;
  int  core_lat = 3;
  bit  core_auto = 1'b1;
  bit  man_fin = 1'b0;
  logic [7:0] sb[$];

  bit           pend;
  int           ccnt;
  logic [255:0] cres;

  always #5 clk = ~clk;

  rsa_stream_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_rx_ready(rx_ready), .i_rekey(rekey), .o_tx_data(tx_data), .o_tx_valid(tx_valid),
    .i_tx_ready(tx_ready), .o_core_start(core_start), .o_core_n(core_n),
    .o_core_d(core_d), .o_core_a(core_a), .i_core_a_pow_d(core_res),
    .i_core_finished(core_fin), .o_busy(busy)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] modexp(input logic [255:0] a, input logic [255:0] d,
                                          input logic [255:0] n);
    longint unsigned r = 1, aa = 64'(a[31:0]), nn = 64'(n[31:0]);
    int dd = (d[31:0] > 32'd64) ? 64 : int'(d[31:0]);
    if (nn == 0) return 256'd0;
    for (int i = 0; i < dd; i++) r = (r * aa) % nn;
    return {8'hA5, 216'd0, 32'(r)};
  endfunction

  // Mock core: answers each start after core_lat cycles, or on a manual request.
  initial begin
    core_fin = 1'b0; core_res = 256'd0; pend = 1'b0; ccnt = 0; cres = 256'd0;
    forever begin
      @(negedge clk);
      core_fin = 1'b0;
      if (man_fin) begin
        core_fin = 1'b1; core_res = {8'h5A, 240'd0, 8'hEE}; man_fin = 1'b0;
      end else if (pend) begin
        if (ccnt == 0) begin core_fin = 1'b1; core_res = cres; pend = 1'b0; end
        else ccnt--;
      end
      if (core_start) begin
        start_cnt++;
        if (core_auto) begin pend = 1'b1; ccnt = core_lat; cres = modexp(core_a, core_d, core_n); end
      end
    end
  end

  // Tx monitor: scoreboard pop on every accepted byte, hold check while stalled.
  initial begin
    logic [7:0] held;
    bit stalled;
    stalled = 1'b0; held = 8'h00;
    forever begin
      @(negedge clk);
      if (stalled && tx_valid) chk("tx_hold", {248'd0, tx_data}, {248'd0, held});
      stalled = tx_valid && !tx_ready;
      held = tx_data;
      if (tx_valid && tx_ready) begin
        tx_seen++;
        n_checks++;
        assert (sb.size() > 0) else begin
          n_fail++;
          $error("FAIL tx_unexpected: got byte %02h, expected no output", tx_data);
        end
        if (sb.size() > 0) chk("tx_byte", {248'd0, tx_data}, {248'd0, sb.pop_front()});
      end
    end
  end

  task automatic push_exp(input logic [7:0] v);
    for (int i = 0; i < 30; i++) sb.push_back(8'h00);
    sb.push_back(v);
  endtask

  task automatic send_word(input logic [255:0] w, input bit gaps);
    int t;
    bit acc;
    tick();
    for (int i = 31; i >= 0; i--) begin
      if (gaps) begin
        repeat ($urandom_range(2, 0)) begin
          rx_valid = 1'b0; rx_data = 8'($urandom); tick();
        end
      end
      rx_data = w[8*i +: 8]; rx_valid = 1'b1; t = 0; acc = 1'b0;
      while (!acc && t < 100) begin
        @(negedge clk); acc = rx_ready; tick(); t++;
      end
      chk("rx_accept", {255'd0, acc}, {255'd0, 1'b1});
      rx_valid = 1'b0;
    end
  endtask

  task automatic check_start(input logic [255:0] n, input logic [255:0] d, input logic [255:0] a);
    @(negedge clk);
    chk("start_pulse", {255'd0, core_start}, 256'd1);
    chk("start_busy", {255'd0, busy}, 256'd1);
    chk("start_rx_ready", {255'd0, rx_ready}, 256'd0);
    chk("op_n", core_n, n);
    chk("op_d", core_d, d);
    chk("op_a", core_a, a);
    @(negedge clk);
    chk("start_one_cycle", {255'd0, core_start}, 256'd0);
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 3000 && sb.size() != 0; t++) tick();
    chk({tag, "_drained"}, 256'(sb.size()), 256'd0);
    @(negedge clk);
    chk({tag, "_rx_ready"}, {255'd0, rx_ready}, 256'd1);
    chk({tag, "_idle"}, {254'd0, busy, tx_valid}, 256'd0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ctl"}, {252'd0, rx_ready, tx_valid, core_start, busy}, 256'd0);
    chk({tag, "_n"}, core_n, 256'd0);
    chk({tag, "_d"}, core_d, 256'd0);
    chk({tag, "_a"}, core_a, 256'd0);
    chk({tag, "_txd"}, {248'd0, tx_data}, 256'd0);
  endtask

  initial begin
    int s0, base, t;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rekey = 1'b0; tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_checks("rst0");
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {255'd0, rx_ready}, 256'd1);

    // Basic flow: 5^9 mod 7 = 6
    s0 = start_cnt;
    send_word(256'd7, 1'b0); send_word(256'd9, 1'b0);
    push_exp(8'h06); send_word(256'd5, 1'b0);
    check_start(256'd7, 256'd9, 256'd5);
    drain("basic");
    chk("start_count", 256'(start_cnt - s0), 256'd1);

    // Reuse keys: 3^9 mod 7 = 6
    push_exp(8'h06); send_word(256'd3, 1'b1);
    check_start(256'd7, 256'd9, 256'd3);
    drain("reuse");

    // Backpressure: 4^9 mod 7 = 1, stall after 10 bytes
    base = tx_seen;
    push_exp(8'h01); send_word(256'd4, 1'b1);
    check_start(256'd7, 256'd9, 256'd4);
    for (t = 0; t < 500 && tx_seen < base + 10; t++) tick();
    tx_ready = 1'b0;
    repeat (10) begin rx_valid = 1'($urandom_range(1, 0)); rx_data = 8'($urandom); tick(); end
    rx_valid = 1'b0;
    chk("stall_no_bytes", 256'(tx_seen - base), 256'd10);
    tx_ready = 1'b1;
    drain("bp");

    // Rekey at block boundary: 2^3 mod 11 = 8
    tick(); rekey = 1'b1;
    @(negedge clk);
    chk("rekey_cycle_ready", {255'd0, rx_ready}, 256'd0);
    tick(); rekey = 1'b0;
    @(negedge clk);
    chk("rekey_get_n_ready", {255'd0, rx_ready}, 256'd1);
    send_word(256'd11, 1'b0); send_word(256'd3, 1'b0);
    push_exp(8'h08); send_word(256'd2, 1'b0);
    check_start(256'd11, 256'd3, 256'd2);
    drain("rekey");

    // Rekey during WAIT is dropped: 3^3 mod 11 = 5, then keys still N=11, D=3
    core_lat = 20;
    push_exp(8'h05); send_word(256'd3, 1'b0);
    check_start(256'd11, 256'd3, 256'd3);
    tick(); rekey = 1'b1; tick(); rekey = 1'b0;
    drain("rekey_wait");
    core_lat = 3;
    push_exp(8'h08); send_word(256'd2, 1'b0);
    check_start(256'd11, 256'd3, 256'd2);
    drain("keys_kept");

    // Reset during WAIT, then a late finished pulse must be ignored
    core_auto = 1'b0;
    send_word(256'd9, 1'b0);
    check_start(256'd11, 256'd3, 256'd9);
    repeat (3) tick();
    rst = 1'b1; tick(); tick();
    @(negedge clk);
    reset_checks("rst_wait");
    tick(); rst = 1'b0; man_fin = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("late_fin_idle", {253'd0, busy, tx_valid, rx_ready}, 256'd1);
    end
    core_auto = 1'b1;

    // Reset during SEND
    base = tx_seen;
    send_word(256'd7, 1'b0); send_word(256'd9, 1'b0);
    push_exp(8'h06); send_word(256'd5, 1'b0);
    check_start(256'd7, 256'd9, 256'd5);
    for (t = 0; t < 500 && tx_seen < base + 5; t++) tick();
    tx_ready = 1'b0; tick(); rst = 1'b1; tick();
    @(negedge clk);
    reset_checks("rst_send");
    sb.delete();
    tick(); rst = 1'b0; tx_ready = 1'b1;
    @(negedge clk);
    chk("rst_send_after", {254'd0, tx_valid, rx_ready}, 256'd1);

    // Full sequence after reset
    send_word(256'd7, 1'b0); send_word(256'd9, 1'b0);
    push_exp(8'h06); send_word(256'd5, 1'b0);
    check_start(256'd7, 256'd9, 256'd5);
    drain("post_rst");

    // Spurious finished in GET_A: 2^9 mod 7 = 1 afterwards
    man_fin = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("spurious_fin", {253'd0, busy, tx_valid, rx_ready}, 256'd1);
    end
    push_exp(8'h01); send_word(256'd2, 1'b0);
    check_start(256'd7, 256'd9, 256'd2);
    drain("spurious");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rsa_stream_ctrl.md
# rsa_stream_ctrl

Byte-stream controller that sequences one `Rsa256Core` instance. It receives modulus N, exponent D and a sequence of 256-bit ciphertext blocks A over an 8-bit valid/ready input stream. It starts the core for each block and returns the low 248 bits of each result as 31 bytes over an 8-bit valid/ready output stream. It sits between the UART/host byte link and the core, and keeps the key pair across blocks until re-keyed.

## Interface
- `BYTES_IN`, default 32: bytes per received word (N, D, A); word width is 8*BYTES_IN.
- `BYTES_OUT`, default 31: bytes returned per result; taken from result bits [8*BYTES_OUT-1:0].
- `i_clk` input 1: clock, rising edge.
- `i_rst` input 1: synchronous reset, active-high.
- `i_rx_data` input 8: incoming byte.
- `i_rx_valid` input 1: incoming byte valid.
- `o_rx_ready` output 1: controller can accept a byte.
- `i_rekey` input 1: request to reload N and D; honoured only at a block boundary.
- `o_tx_data` output 8: outgoing byte.
- `o_tx_valid` output 1: outgoing byte valid.
- `i_tx_ready` input 1: sink accepts the byte.
- `o_core_start` output 1: one-cycle start pulse to the core.
- `o_core_n`, `o_core_d`, `o_core_a` output 256: operands, held stable from start until finished.
- `i_core_a_pow_d` input 256: core result.
- `i_core_finished` input 1: core done pulse.
- `o_busy` output 1: high in S_START, S_WAIT, S_SEND.

## Operation
- States: S_GET_N → S_GET_D → S_GET_A → S_START → S_WAIT → S_SEND → S_GET_A.
- A byte is accepted on any cycle with `i_rx_valid & o_rx_ready`. `o_rx_ready` = 1 exactly in the S_GET_* states.
- Words arrive MSB-first. Each accepted byte does reg <= {reg[247:0], byte}, and the 6-bit byte counter increments.
- When the BYTES_IN-th byte is accepted, the counter clears and the FSM advances to the next state.
- S_START lasts one cycle with `o_core_start`=1, then the FSM enters S_WAIT.
- In S_WAIT, when `i_core_finished`=1, `i_core_a_pow_d[247:0]` is loaded into the tx shift register and the FSM goes to S_SEND. `i_core_finished` is ignored in all other states.
- In S_SEND, `o_tx_valid`=1 and `o_tx_data` = tx_reg[247:240].
  - On `o_tx_valid & i_tx_ready`: shift left by 8 and increment the counter.
  - After the BYTES_OUT-th byte: clear the counter and go to S_GET_A. N and D are retained.
- Rekey: `i_rekey` is sampled only in S_GET_A with counter==0. If high, the FSM goes to S_GET_N and that cycle accepts no byte (`o_rx_ready`=0 for that cycle). A rekey pulse arriving at any other time is dropped.
- Reset, including mid-block, mid-wait or mid-send:
  - State S_GET_N; counters 0; N, D, A and tx registers all 0.
  - `o_core_start`=0, `o_tx_valid`=0, `o_rx_ready`=0 during reset, `o_busy`=0.
  - A pending core result is discarded.

## Timing
- Out of reset, `o_rx_ready`=1 in the first cycle after `i_rst` deasserts.
- Throughput is one byte per cycle in each direction when the partner is always ready.
- Last A byte accepted at edge k → `o_core_start` high in cycle k+1 → S_WAIT from k+2.
- `i_core_finished` sampled at edge m → first `o_tx_valid` in cycle m+1.
- Last tx byte accepted at edge t → `o_rx_ready`=1 in cycle t+1.
- While `o_tx_valid`=1 and `i_tx_ready`=0, `o_tx_data` holds stable.
- `o_core_*` operands change only in the S_GET_* states.
- Minimum latency from last A byte to first output byte is core latency + 2 cycles.

## Structure
- Package `rsa_ctrl_pkg`:
  - `state_t` enum (S_GET_N, S_GET_D, S_GET_A, S_START, S_WAIT, S_SEND).
  - `WORD_W`=256 and `BYTE_W`=8.
- One sub-module, `rsa_byte_shifter`: a parameterised shift register with load/shift-in/shift-out enables. It is instantiated for rx assembly and tx serialisation.
- `Rsa256Core` is instantiated by the parent, not inside this block.

## Test plan
- Basic flow, real core: reset, then send N=7, D=9, A=5 (each as 31×0x00 then the value byte). Expect `o_core_start` high for exactly one cycle, then 31 output bytes: 30×0x00 then 0x06.
- Reuse keys: after the basic flow, send only A=3. Expect output 30×0x00 then 0x06 (3^9 mod 7 = 6), with no re-entry to S_GET_N.
- Backpressure: hold `i_tx_ready`=0 for 10 cycles mid-output and randomly toggle `i_rx_valid`. Expect no lost or duplicated bytes and `o_tx_data` stable while stalled.
- Rekey: pulse `i_rekey` in S_GET_A at counter 0, then send N=11, D=3, A=2. Expect result byte 0x08. Separately, a rekey pulse during S_WAIT must be ignored.
- Reset mid-operation: assert `i_rst` during S_WAIT and again during S_SEND. Expect all outputs return to reset values and a late `i_core_finished` produces no tx output; a full N/D/A sequence then works normally.
- Spurious finished: a mock core pulses `i_core_finished` during S_GET_A. Expect no state change and no tx output.
